// File: rtl/mmu_req_dispatcher_pkg.sv
// rtl/mmu_req_dispatcher_pkg.sv - shared widths, response-source encoding and drain states
package mmu_req_dispatcher_pkg;

  localparam int REQ_ID_WIDTH        = 8;
  localparam int REQ_SIZE_TYPE_WIDTH = 8;
  localparam int ALL_PAGE_IDX_WIDTH  = 10;
  localparam int FAIL_REASON_WIDTH   = 2;

  typedef enum logic {
    SRC_ALLOC = 1'b0,
    SRC_FREE  = 1'b1
  } rsp_src_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/mmu_tag_pool.sv
// rtl/mmu_tag_pool.sv - outstanding-tag bitmap with lowest-free encoder (busy map exported under MMU_DISP_ID_CHECK_EN)
module mmu_tag_pool
  import mmu_req_dispatcher_pkg::*;
#(
  parameter int N  = 16,
  parameter int LW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          rel,
  input  logic [LW-1:0] rel_idx,
  output logic [LW-1:0] free_idx,
  output logic          full
`ifdef MMU_DISP_ID_CHECK_EN
  ,
  output logic [N-1:0]  busy_map
`endif
);

  logic [N-1:0] busy;

  // Lowest clear bit: scan downward so the smallest index wins last.
  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = LW'(i);
    end
  end

  assign full = &busy;

`ifdef MMU_DISP_ID_CHECK_EN
  assign busy_map = busy;
`endif

  // Release then allocate; the allocated index comes from the pre-release map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (rel)   busy[rel_idx]  <= 1'b0;
      if (alloc) busy[free_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/mmu_req_dispatcher.sv
// rtl/mmu_req_dispatcher.sv - tags client alloc/free commands into mmu_top and returns responses (optional MMU_DISP_ID_CHECK_EN)
module mmu_req_dispatcher
  import mmu_req_dispatcher_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int ID_W            = REQ_ID_WIDTH,
  parameter int CNT_W           = REQ_SIZE_TYPE_WIDTH,
  parameter int IDX_W           = ALL_PAGE_IDX_WIDTH,
  parameter int FR_W            = FAIL_REASON_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_is_free,
  input  logic [CNT_W-1:0] cmd_page_count,
  input  logic [IDX_W-1:0] cmd_page_idx,
  output logic [ID_W-1:0]  cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_is_free,
  output logic [ID_W-1:0]  rsp_tag,
  output logic [IDX_W-1:0] rsp_page_idx,
  output logic             rsp_fail,
  output logic [FR_W-1:0]  rsp_fail_reason,
  output logic             alloc_req_submit,
  output logic [ID_W-1:0]  alloc_req_id,
  output logic [CNT_W-1:0] alloc_req_page_count,
  output logic             free_req_submit,
  output logic [ID_W-1:0]  free_req_id,
  output logic [IDX_W-1:0] free_req_page_idx,
  output logic [CNT_W-1:0] free_req_page_count,
  input  logic             alloc_req_fifo_full,
  input  logic             free_req_fifo_full,
  output logic             alloc_rsp_pop,
  output logic             free_rsp_pop,
  input  logic             alloc_rsp_fifo_not_empty,
  input  logic             free_rsp_fifo_not_empty,
  input  logic [ID_W-1:0]  alloc_rsp_id,
  input  logic [IDX_W-1:0] alloc_rsp_page_idx,
  input  logic             alloc_rsp_fail,
  input  logic [FR_W-1:0]  alloc_rsp_fail_reason,
  input  logic [ID_W-1:0]  free_rsp_id,
  input  logic             free_rsp_fail,
  input  logic [FR_W-1:0]  free_rsp_fail_reason
`ifdef MMU_DISP_ID_CHECK_EN
  ,
  output logic             err_spurious_id
`endif
);

  localparam int LW = $clog2(MAX_OUTSTANDING);

  logic          pool_full;
  logic [LW-1:0] free_idx;
  logic          accept;
  logic          sel_fifo_full;
  logic          rsp_release;

  rsp_state_e    state_q, state_d;
  rsp_src_e      last_served;
  logic          pick_free;
  logic          pop_any;
  logic          load;
  logic          id_ok;

  logic [ID_W-1:0]  head_id;
  logic [IDX_W-1:0] head_page_idx;
  logic             head_fail;
  logic [FR_W-1:0]  head_fail_reason;

`ifdef MMU_DISP_ID_CHECK_EN
  logic [MAX_OUTSTANDING-1:0] busy_map;
  logic [MAX_OUTSTANDING-1:0] busy_live;
`endif

  // Command side: zero-latency accept straight into the selected request FIFO.
  assign sel_fifo_full        = cmd_is_free ? free_req_fifo_full : alloc_req_fifo_full;
  assign cmd_ready            = !rst && !pool_full && !sel_fifo_full;
  assign accept               = cmd_valid && cmd_ready;
  assign cmd_tag              = ID_W'(free_idx);
  assign alloc_req_submit     = accept && !cmd_is_free;
  assign free_req_submit      = accept && cmd_is_free;
  assign alloc_req_id         = cmd_tag;
  assign free_req_id          = cmd_tag;
  assign alloc_req_page_count = cmd_page_count;
  assign free_req_page_count  = cmd_page_count;
  assign free_req_page_idx    = cmd_page_idx;

  assign rsp_valid   = (state_q == RSP_FULL);
  assign rsp_release = rsp_valid && rsp_ready;

  mmu_tag_pool #(
    .N  (MAX_OUTSTANDING),
    .LW (LW)
  ) u_tag_pool (
    .clk      (clk),
    .rst      (rst),
    .alloc    (accept),
    .rel      (rsp_release),
    .rel_idx  (rsp_tag[LW-1:0]),
    .free_idx (free_idx),
    .full     (pool_full)
`ifdef MMU_DISP_ID_CHECK_EN
    ,
    .busy_map (busy_map)
`endif
  );

  // Round-robin pick: on a tie serve the source opposite the last one served.
  always_comb begin
    pick_free = free_rsp_fifo_not_empty;
    if (alloc_rsp_fifo_not_empty && free_rsp_fifo_not_empty) begin
      pick_free = (last_served == SRC_ALLOC);
    end
  end

  assign head_id          = pick_free ? free_rsp_id : alloc_rsp_id;
  assign head_page_idx    = pick_free ? '0 : alloc_rsp_page_idx;
  assign head_fail        = pick_free ? free_rsp_fail : alloc_rsp_fail;
  assign head_fail_reason = pick_free ? free_rsp_fail_reason : alloc_rsp_fail_reason;

`ifdef MMU_DISP_ID_CHECK_EN
  // A tag being released this cycle no longer counts as outstanding.
  assign busy_live = busy_map & ~(rsp_release ? (MAX_OUTSTANDING'(1) << rsp_tag[LW-1:0])
                                              : '0);
  assign id_ok     = (32'(head_id) < 32'(MAX_OUTSTANDING)) && busy_live[head_id[LW-1:0]];
`else
  assign id_ok     = 1'b1;
`endif

  // Drain FSM next state and pop strobes; a full register may drain and refill together.
  always_comb begin
    state_d       = state_q;
    pop_any       = 1'b0;
    alloc_rsp_pop = 1'b0;
    free_rsp_pop  = 1'b0;
    if (!rst && (state_q == RSP_EMPTY || rsp_ready) &&
        (alloc_rsp_fifo_not_empty || free_rsp_fifo_not_empty)) begin
      pop_any       = 1'b1;
      alloc_rsp_pop = !pick_free;
      free_rsp_pop  = pick_free;
    end
    load = pop_any && id_ok;
    case (state_q)
      RSP_EMPTY: if (load) state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !load) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RSP_EMPTY;
    else     state_q <= state_d;
  end

  // Output register: capture the selected FIFO head on an accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_is_free     <= 1'b0;
      rsp_tag         <= '0;
      rsp_page_idx    <= '0;
      rsp_fail        <= 1'b0;
      rsp_fail_reason <= '0;
    end else if (load) begin
      rsp_is_free     <= pick_free;
      rsp_tag         <= head_id;
      rsp_page_idx    <= head_page_idx;
      rsp_fail        <= head_fail;
      rsp_fail_reason <= head_fail_reason;
    end
  end

  // Remember which source was popped last for the next tie-break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_served <= SRC_FREE;
    else if (pop_any) last_served <= pick_free ? SRC_FREE : SRC_ALLOC;
  end

`ifdef MMU_DISP_ID_CHECK_EN
  // Sticky flag for a popped response whose tag is unknown or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  err_spurious_id <= 1'b0;
    else if (pop_any && !id_ok) err_spurious_id <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mmu_req_dispatcher.sv
// tb/tb_mmu_req_dispatcher.sv - directed bench for mmu_req_dispatcher (MMU_DISP_ID_CHECK_EN section when defined)
module tb_mmu_req_dispatcher;
  import mmu_req_dispatcher_pkg::*;

  localparam int ID_W  = REQ_ID_WIDTH;
  localparam int CNT_W = REQ_SIZE_TYPE_WIDTH;
  localparam int IDX_W = ALL_PAGE_IDX_WIDTH;
  localparam int FR_W  = FAIL_REASON_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_is_free;
  logic [CNT_W-1:0] cmd_page_count;
  logic [IDX_W-1:0] cmd_page_idx;
  logic [ID_W-1:0]  cmd_tag;
  logic             rsp_valid, rsp_ready, rsp_is_free, rsp_fail;
  logic [ID_W-1:0]  rsp_tag;
  logic [IDX_W-1:0] rsp_page_idx;
  logic [FR_W-1:0]  rsp_fail_reason;
  logic             alloc_req_submit, free_req_submit;
  logic [ID_W-1:0]  alloc_req_id, free_req_id;
  logic [CNT_W-1:0] alloc_req_page_count, free_req_page_count;
  logic [IDX_W-1:0] free_req_page_idx;
  logic             alloc_req_fifo_full, free_req_fifo_full;
  logic             alloc_rsp_pop, free_rsp_pop;
  logic             alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty;
  logic [ID_W-1:0]  alloc_rsp_id, free_rsp_id;
  logic [IDX_W-1:0] alloc_rsp_page_idx;
  logic             alloc_rsp_fail, free_rsp_fail;
  logic [FR_W-1:0]  alloc_rsp_fail_reason, free_rsp_fail_reason;
`ifdef MMU_DISP_ID_CHECK_EN
  logic             err_spurious_id;
`endif

  mmu_req_dispatcher dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_free(cmd_is_free),
    .cmd_page_count(cmd_page_count), .cmd_page_idx(cmd_page_idx), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_free(rsp_is_free),
    .rsp_tag(rsp_tag), .rsp_page_idx(rsp_page_idx), .rsp_fail(rsp_fail),
    .rsp_fail_reason(rsp_fail_reason),
    .alloc_req_submit(alloc_req_submit), .alloc_req_id(alloc_req_id),
    .alloc_req_page_count(alloc_req_page_count),
    .free_req_submit(free_req_submit), .free_req_id(free_req_id),
    .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
    .alloc_req_fifo_full(alloc_req_fifo_full), .free_req_fifo_full(free_req_fifo_full),
    .alloc_rsp_pop(alloc_rsp_pop), .free_rsp_pop(free_rsp_pop),
    .alloc_rsp_fifo_not_empty(alloc_rsp_fifo_not_empty),
    .free_rsp_fifo_not_empty(free_rsp_fifo_not_empty),
    .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
    .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
    .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
    .free_rsp_fail_reason(free_rsp_fail_reason)
`ifdef MMU_DISP_ID_CHECK_EN
    ,
    .err_spurious_id(err_spurious_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [IDX_W-1:0] pidx;
    logic             fail;
    logic [FR_W-1:0]  fr;
  } rsp_t;

  typedef struct packed {
    logic             valid;
    logic             is_free;
    logic             a_full;
    logic             f_full;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             e_ready;
    logic [ID_W-1:0]  e_tag;
    logic             e_asub;
    logic             e_fsub;
  } cmd_vec_t;

  typedef struct packed {
    logic             e_apop;
    logic             e_fpop;
    logic             e_valid;
    logic             e_is_free;
    logic [ID_W-1:0]  e_tag;
    logic [IDX_W-1:0] e_pidx;
    logic             e_fail;
    logic [FR_W-1:0]  e_fr;
  } rsp_vec_t;

  rsp_t     aq[$];
  rsp_t     fq[$];
  cmd_vec_t cvec[7];
  rsp_vec_t rvec[6];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic update_heads();
    alloc_rsp_fifo_not_empty = (aq.size() != 0);
    free_rsp_fifo_not_empty  = (fq.size() != 0);
    if (aq.size() != 0) begin
      alloc_rsp_id = aq[0].id; alloc_rsp_page_idx = aq[0].pidx;
      alloc_rsp_fail = aq[0].fail; alloc_rsp_fail_reason = aq[0].fr;
    end else begin
      alloc_rsp_id = '0; alloc_rsp_page_idx = '0; alloc_rsp_fail = 1'b0; alloc_rsp_fail_reason = '0;
    end
    if (fq.size() != 0) begin
      free_rsp_id = fq[0].id; free_rsp_fail = fq[0].fail; free_rsp_fail_reason = fq[0].fr;
    end else begin
      free_rsp_id = '0; free_rsp_fail = 1'b0; free_rsp_fail_reason = '0;
    end
  endtask

  // Pops are sampled before the edge; the FIFO model advances just after it.
  task automatic tick();
    logic ap, fp;
    ap = alloc_rsp_pop;
    fp = free_rsp_pop;
    @(posedge clk);
    #1;
    if (ap && aq.size() != 0) void'(aq.pop_front());
    if (fp && fq.size() != 0) void'(fq.pop_front());
    update_heads();
  endtask

  task automatic alloc_one(input logic [ID_W-1:0] exp_tag);
    cmd_valid = 1'b1; cmd_is_free = 1'b0; cmd_page_count = 8'd1;
    #1;
    chk("alloc_tag", cmd_tag, exp_tag);
    chk("alloc_submit", alloc_req_submit, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_is_free = 1'b0; cmd_page_count = '0; cmd_page_idx = '0;
    rsp_ready = 1'b0; alloc_req_fifo_full = 1'b0; free_req_fifo_full = 1'b0;
    update_heads();

    //             v  fr af ff cnt    idx      rdy tag   as fs
    cvec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 10'd0,   1'b1, 8'd0, 1'b1, 1'b0};
    cvec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 10'd0,   1'b1, 8'd1, 1'b1, 1'b0};
    cvec[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 10'd0,   1'b0, 8'd2, 1'b0, 1'b0};
    cvec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd4, 10'd77,  1'b1, 8'd2, 1'b0, 1'b1};
    cvec[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 10'd78,  1'b0, 8'd3, 1'b0, 1'b0};
    cvec[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd6, 10'd0,   1'b1, 8'd3, 1'b0, 1'b0};
    cvec[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd7, 10'd0,   1'b1, 8'd3, 1'b1, 1'b0};

    //            ap    fp    v     free  tag   pidx     fail  fr
    rvec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0,   1'b0, 2'd0};
    rvec[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 10'd100, 1'b0, 2'd0};
    rvec[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 10'd0,   1'b0, 2'd0};
    rvec[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 10'd101, 1'b1, 2'd2};
    rvec[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 10'd0,   1'b1, 2'd3};
    rvec[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'd0,   1'b0, 2'd0};

    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_tag", rsp_tag, '0);
    chk("reset_rsp_page_idx", rsp_page_idx, '0);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    #1;
    chk("reset_alloc_submit", alloc_req_submit, 1'b0);
    chk("reset_alloc_pop", alloc_rsp_pop, 1'b0);
`ifdef MMU_DISP_ID_CHECK_EN
    chk("reset_err", err_spurious_id, 1'b0);
`endif
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Command table: tagging, FIFO-full gating, pass-through fields.
    for (int i = 0; i < 7; i++) begin
      cmd_valid = cvec[i].valid; cmd_is_free = cvec[i].is_free;
      alloc_req_fifo_full = cvec[i].a_full; free_req_fifo_full = cvec[i].f_full;
      cmd_page_count = cvec[i].cnt; cmd_page_idx = cvec[i].idx;
      #1;
      chk($sformatf("vec%0d_ready", i), cmd_ready, cvec[i].e_ready);
      chk($sformatf("vec%0d_tag", i), cmd_tag, cvec[i].e_tag);
      chk($sformatf("vec%0d_asub", i), alloc_req_submit, cvec[i].e_asub);
      chk($sformatf("vec%0d_fsub", i), free_req_submit, cvec[i].e_fsub);
      if (cvec[i].e_asub) begin
        chk($sformatf("vec%0d_aid", i), alloc_req_id, cvec[i].e_tag);
        chk($sformatf("vec%0d_acnt", i), alloc_req_page_count, cvec[i].cnt);
      end
      if (cvec[i].e_fsub) begin
        chk($sformatf("vec%0d_fid", i), free_req_id, cvec[i].e_tag);
        chk($sformatf("vec%0d_fidx", i), free_req_page_idx, cvec[i].idx);
        chk($sformatf("vec%0d_fcnt", i), free_req_page_count, cvec[i].cnt);
      end
      tick();
    end
    cmd_valid = 1'b0; alloc_req_fifo_full = 1'b0; free_req_fifo_full = 1'b0;

    // Fill the pool, then the seventeenth command must stall.
    for (int i = 4; i < 16; i++) alloc_one(ID_W'(i));
    cmd_valid = 1'b1; cmd_is_free = 1'b0;
    #1;
    chk("pool_full_ready", cmd_ready, 1'b0);
    chk("pool_full_submit", alloc_req_submit, 1'b0);
    cmd_valid = 1'b0;
    tick();

    // Return tag 5; it becomes the next tag handed out.
    aq.push_back('{id: 8'd5, pidx: 10'd33, fail: 1'b0, fr: 2'd0});
    update_heads();
    #1;
    chk("ret5_pop", alloc_rsp_pop, 1'b1);
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("ret5_valid", rsp_valid, 1'b1);
    chk("ret5_tag", rsp_tag, 8'd5);
    chk("ret5_pidx", rsp_page_idx, 10'd33);
    chk("ret5_still_full", cmd_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("ret5_drained", rsp_valid, 1'b0);
    chk("ret5_ready", cmd_ready, 1'b1);
    chk("ret5_reuse_tag", cmd_tag, 8'd5);
    alloc_one(8'd5);

    // Mid-operation reset empties the pool.
    do_reset();
    #1;
    chk("post_rst_tag", cmd_tag, 8'd0);
    chk("post_rst_ready", cmd_ready, 1'b1);

    // Alternating drain with both FIFOs non-empty.
    for (int i = 0; i < 4; i++) alloc_one(ID_W'(i));
    aq.push_back('{id: 8'd0, pidx: 10'd100, fail: 1'b0, fr: 2'd0});
    aq.push_back('{id: 8'd1, pidx: 10'd101, fail: 1'b1, fr: 2'd2});
    fq.push_back('{id: 8'd2, pidx: 10'd0,   fail: 1'b0, fr: 2'd0});
    fq.push_back('{id: 8'd3, pidx: 10'd0,   fail: 1'b1, fr: 2'd3});
    update_heads();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d_apop", k), alloc_rsp_pop, rvec[k].e_apop);
      chk($sformatf("rr%0d_fpop", k), free_rsp_pop, rvec[k].e_fpop);
      chk($sformatf("rr%0d_valid", k), rsp_valid, rvec[k].e_valid);
      if (rvec[k].e_valid) begin
        chk($sformatf("rr%0d_is_free", k), rsp_is_free, rvec[k].e_is_free);
        chk($sformatf("rr%0d_tag", k), rsp_tag, rvec[k].e_tag);
        chk($sformatf("rr%0d_pidx", k), rsp_page_idx, rvec[k].e_pidx);
        chk($sformatf("rr%0d_fail", k), rsp_fail, rvec[k].e_fail);
        chk($sformatf("rr%0d_fr", k), rsp_fail_reason, rvec[k].e_fr);
      end
      tick();
    end

    // Backpressure: hold, then drain and refill in one cycle.
    rsp_ready = 1'b0;
    alloc_one(8'd0);
    alloc_one(8'd1);
    aq.push_back('{id: 8'd0, pidx: 10'd200, fail: 1'b0, fr: 2'd0});
    aq.push_back('{id: 8'd1, pidx: 10'd201, fail: 1'b0, fr: 2'd1});
    update_heads();
    #1;
    chk("bp_first_pop", alloc_rsp_pop, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_valid", k), rsp_valid, 1'b1);
      chk($sformatf("bp%0d_tag", k), rsp_tag, 8'd0);
      chk($sformatf("bp%0d_pidx", k), rsp_page_idx, 10'd200);
      chk($sformatf("bp%0d_nopop", k), alloc_rsp_pop, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_refill_pop", alloc_rsp_pop, 1'b1);
    tick();
    #1;
    chk("bp_refill_valid", rsp_valid, 1'b1);
    chk("bp_refill_tag", rsp_tag, 8'd1);
    chk("bp_refill_pidx", rsp_page_idx, 10'd201);
    chk("bp_refill_fr", rsp_fail_reason, 2'd1);
    chk("bp_refill_nopop", alloc_rsp_pop, 1'b0);
    tick();
    #1;
    chk("bp_empty", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

`ifdef MMU_DISP_ID_CHECK_EN
    // Spurious ID on an idle tag is dropped and flagged until reset.
    do_reset();
    aq.push_back('{id: 8'd9, pidx: 10'd5, fail: 1'b0, fr: 2'd0});
    update_heads();
    #1;
    chk("spur_pop", alloc_rsp_pop, 1'b1);
    tick();
    #1;
    chk("spur_no_valid", rsp_valid, 1'b0);
    chk("spur_err", err_spurious_id, 1'b1);
    tick();
    #1;
    chk("spur_err_sticky", err_spurious_id, 1'b1);
    do_reset();
    #1;
    chk("spur_err_cleared", err_spurious_id, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_req_dispatcher.md
# mmu_req_dispatcher

Client-facing front end placed directly upstream of `mmu_top`. Accepts alloc/free commands from one client over a valid/ready handshake, tags each with a request ID from a pool of outstanding slots, and pushes it into `mmu_top`'s alloc or free request FIFO. It also drains both `mmu_top` response FIFOs with round-robin arbitration and returns each response to the client through one registered valid/ready port. The ID is released when the client accepts the response.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 16: number of tags in the pool; power of two, 2..64.
- `ID_W`, `` `REQ_ID_WIDTH ``: request ID width; must be ≥ clog2(`MAX_OUTSTANDING`).
- `CNT_W`, `` `REQ_SIZE_TYPE_WIDTH ``: page-count width.
- `IDX_W`, `` `ALL_PAGE_IDX_WIDTH ``: page-index width.
- `FR_W`, `` `FAIL_REASON_WIDTH ``: fail-reason width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: client command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_is_free` in 1: 1 selects free, 0 selects alloc.
- `cmd_page_count` in `CNT_W`: page count.
- `cmd_page_idx` in `IDX_W`: page index (free only).
- `cmd_tag` out `ID_W`: tag assigned to this command; valid while `cmd_ready`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: client accepts response.
- `rsp_is_free` out 1: response came from the free path.
- `rsp_tag` out `ID_W`: tag of the completed request.
- `rsp_page_idx` out `IDX_W`: allocated page index (alloc only; 0 for free).
- `rsp_fail` out 1: request failed.
- `rsp_fail_reason` out `FR_W`: fail reason.
- `alloc_req_submit`, `alloc_req_id`, `alloc_req_page_count` out: to `mmu_top`.
- `free_req_submit`, `free_req_id`, `free_req_page_idx`, `free_req_page_count` out: to `mmu_top`.
- `alloc_req_fifo_full`, `free_req_fifo_full` in 1: from `mmu_top`.
- `alloc_rsp_pop`, `free_rsp_pop` out 1: one-cycle pop pulses to `mmu_top`.
- `alloc_rsp_fifo_not_empty`, `free_rsp_fifo_not_empty` in 1: from `mmu_top`.
- `alloc_rsp_id`, `alloc_rsp_page_idx`, `alloc_rsp_fail`, `alloc_rsp_fail_reason` in: alloc response FIFO head.
- `free_rsp_id`, `free_rsp_fail`, `free_rsp_fail_reason` in: free response FIFO head.
- `err_spurious_id` out 1: sticky flag; present only with `MMU_DISP_ID_CHECK_EN`.

## Operation
- **Tag pool:** `MAX_OUTSTANDING`-bit busy bitmap, all zeros at reset. `cmd_tag` is the lowest clear bit, zero-extended to `ID_W`.
- **Command acceptance:**
  - `cmd_ready = !rst && pool_not_full && !(cmd_is_free ? free_req_fifo_full : alloc_req_fifo_full)`.
  - On accept, set the busy bit for `cmd_tag`.
  - On accept, drive the matching `*_req_submit` combinationally for that cycle, with `*_req_id = cmd_tag` and the other fields passed through.
  - The non-selected submit stays 0.
- **Response drain:** an output register with states EMPTY and FULL.
  - A pop is allowed when the register is EMPTY, or when it is FULL and `rsp_ready` is high (drain and refill in the same cycle).
  - If both response FIFOs are non-empty, serve the one opposite `last_served`; `last_served` resets to free, so alloc wins the first tie.
  - The pop cycle captures the FIFO head (first-word-fall-through) into the register. The state becomes FULL on the next edge.
  - FULL → EMPTY on `rsp_valid && rsp_ready` with no refill.
- **Release:** on `rsp_valid && rsp_ready`, clear the busy bit at `rsp_tag[clog2(MAX_OUTSTANDING)-1:0]`.
  - Allocation in the same cycle uses the pre-release bitmap, so a released tag is reusable from the next cycle.
- **Reset mid-operation:** the bitmap clears, the output register empties, and in-flight responses inside `mmu_top` are the owner's responsibility.

## Timing
- Reset values: `rsp_valid` 0; `rsp_*` data 0; `cmd_ready` 0 while `rst` is high; submits 0; pops 0; `err_spurious_id` 0.
- Request path latency is 0 cycles: submit is asserted in the accept cycle.
- Response latency is 1 cycle from pop to `rsp_valid`. Sustained throughput is 1 response per cycle while `rsp_ready` is held high.
- `rsp_*` outputs hold stable while `rsp_valid && !rsp_ready`.
- Pool full (`MAX_OUTSTANDING` busy tags) forces `cmd_ready` to 0 until the next release edge.

## Configuration
- `MMU_DISP_ID_CHECK_EN` defined:
  - A popped response whose ID is out of range, or whose tag is not busy, is dropped (not loaded into the output register).
  - `err_spurious_id` is set and stays set until reset.
- Not defined: the port is absent and every popped response is forwarded unchecked.

## Structure
- Shared package or defines: `REQ_ID_WIDTH`, `REQ_SIZE_TYPE_WIDTH`, `ALL_PAGE_IDX_WIDTH`, `FAIL_REASON_WIDTH`, and the response-source encoding (alloc=0, free=1).
- One sub-module: `mmu_tag_pool` (bitmap, lowest-free priority encoder, allocate/release ports, full flag).

## Test plan
- After reset, alloc cmd (count 1) → `alloc_req_submit` pulses in the same cycle with id 0. Next alloc gets id 1.
- Issue 16 allocs with no responses → 17th sees `cmd_ready`=0. Return and accept id 5 → next accept gets tag 5.
- `alloc_req_fifo_full`=1 with an alloc cmd → `cmd_ready`=0. The same cycle with a free cmd → accepted and `free_req_submit`=1.
- Both response FIFOs non-empty for 4 cycles with `rsp_ready`=1 → responses alternate alloc, free, alloc, free, one per cycle, 1-cycle latency.
- Hold `rsp_ready`=0 with `rsp_valid`=1 for 3 cycles → outputs stable and no pops. Raise `rsp_ready` → drain and refill in the same cycle.
- With `MMU_DISP_ID_CHECK_EN`, inject alloc response id 9 while tag 9 is idle → no `rsp_valid` and `err_spurious_id`=1 until reset.
